// File: rtl/mdio_resp.sv
// rtl/mdio_resp.sv - clause-22 MDIO PHY-side responder with a small register file
// Optional: define MDIO_PREAMBLE_CHECK_EN to require a full 32-bit preamble before a start.
module mdio_resp #(
  parameter logic [4:0]  PHY_ADDR   = 5'h01,
  parameter logic [15:0] ID1        = 16'h0022,
  parameter logic [15:0] ID2        = 16'h1619,
  parameter logic [15:0] STATUS_VAL = 16'h782D
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        wr_stb,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);
  localparam logic [15:0] REG0_DEF = 16'h3100;
  localparam logic [15:0] REG4_DEF = 16'h01E1;

  typedef enum logic [2:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_RDATA, S_WDATA
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  mdc_sync, mdio_sync;
  logic        mdc_prev;
  logic        bit_ev, bit_in, last_bit, pre_ok;
  logic [4:0]  bit_cnt;
  logic [5:0]  pre_cnt;
  logic [14:0] shift;
  logic [15:0] in_word, rd_shift, rd_word;
  logic [4:0]  in_addr, reg_addr;
  logic        is_read, addr_ok;
  logic        oe_nxt, out_nxt, ld_rd, commit;
  logic [15:0] reg0, reg4, reg5, reg6, reg7;

  assign bit_ev  = mdc_sync[1] & ~mdc_prev;
  assign bit_in  = mdio_sync[1];
  assign in_word = {shift, bit_in};
  assign in_addr = in_word[4:0];

`ifdef MDIO_PREAMBLE_CHECK_EN
  assign pre_ok = (pre_cnt == 6'd32);
`else
  assign pre_ok = (pre_cnt != 6'd0);
`endif

  // Index of the final bit event of each multi-bit field
  always_comb begin
    case (state)
      S_OP, S_TA:       last_bit = (bit_cnt == 5'd1);
      S_PHYAD, S_REGAD: last_bit = (bit_cnt == 5'd4);
      S_RDATA:          last_bit = (bit_cnt == 5'd16);
      S_WDATA:          last_bit = (bit_cnt == 5'd15);
      default:          last_bit = 1'b1;
    endcase
  end

  always_comb begin
    case (reg_addr)
      5'd0:    rd_word = reg0;
      5'd1:    rd_word = STATUS_VAL;
      5'd2:    rd_word = ID1;
      5'd3:    rd_word = ID2;
      5'd4:    rd_word = reg4;
      5'd5:    rd_word = reg5;
      5'd6:    rd_word = reg6;
      5'd7:    rd_word = reg7;
      default: rd_word = 16'h0000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (bit_ev) begin
      case (state)
        S_IDLE:  if (!bit_in && pre_ok) state_nxt = S_ST;
        S_ST:    state_nxt = bit_in ? S_OP : S_IDLE;
        S_OP:    if (last_bit) state_nxt = (shift[0] ^ bit_in) ? S_PHYAD : S_IDLE;
        S_PHYAD: if (last_bit) state_nxt = S_REGAD;
        S_REGAD: if (last_bit) state_nxt = S_TA;
        S_TA:    if (last_bit) state_nxt = is_read ? S_RDATA : S_WDATA;
        S_RDATA, S_WDATA: if (last_bit) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // A mismatched address walks the same states but never drives or commits
  always_comb begin
    oe_nxt  = mdio_oe;
    out_nxt = mdio_out;
    ld_rd   = 1'b0;
    commit  = 1'b0;
    if (bit_ev) begin
      case (state)
        S_TA: begin
          if (last_bit && is_read && addr_ok) begin
            oe_nxt  = 1'b1;
            out_nxt = 1'b0;
            ld_rd   = 1'b1;
          end
        end
        S_RDATA: begin
          if (last_bit) begin
            oe_nxt  = 1'b0;
            out_nxt = 1'b1;
          end else if (addr_ok) begin
            out_nxt = rd_shift[15];
          end
        end
        S_WDATA: commit = last_bit && addr_ok;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mdc_sync  <= 2'b00;
      mdio_sync <= 2'b00;
      mdc_prev  <= 1'b0;
      state     <= S_IDLE;
      bit_cnt   <= 5'd0;
      pre_cnt   <= 6'd0;
      shift     <= 15'd0;
      rd_shift  <= 16'd0;
      is_read   <= 1'b0;
      addr_ok   <= 1'b0;
      reg_addr  <= 5'd0;
      mdio_oe   <= 1'b0;
      mdio_out  <= 1'b1;
      wr_stb    <= 1'b0;
      wr_addr   <= 5'd0;
      wr_data   <= 16'd0;
      reg0      <= REG0_DEF;
      reg4      <= REG4_DEF;
      reg5      <= 16'd0;
      reg6      <= 16'd0;
      reg7      <= 16'd0;
    end else begin
      mdc_sync  <= {mdc_sync[0], mdc};
      mdio_sync <= {mdio_sync[0], mdio_in};
      mdc_prev  <= mdc_sync[1];
      state     <= state_nxt;
      mdio_oe   <= oe_nxt;
      mdio_out  <= out_nxt;
      wr_stb    <= commit;
      if (bit_ev) begin
        shift    <= in_word[14:0];
        bit_cnt  <= (state_nxt != state) ? 5'd0 : bit_cnt + 5'd1;
        rd_shift <= ld_rd ? rd_word : {rd_shift[14:0], 1'b0};
        if (state == S_IDLE && state_nxt == S_IDLE && bit_in)
          pre_cnt <= (pre_cnt == 6'd32) ? pre_cnt : pre_cnt + 6'd1;
        else
          pre_cnt <= 6'd0;
        if (state == S_OP && last_bit)    is_read  <= shift[0];
        if (state == S_PHYAD && last_bit) addr_ok  <= (in_addr == PHY_ADDR);
        if (state == S_REGAD && last_bit) reg_addr <= in_addr;
      end
      if (commit) begin
        wr_addr <= reg_addr;
        wr_data <= in_word;
        // Bit 15 of reg 0 is a soft reset: the rest of that word is dropped
        if (reg_addr == 5'd0 && in_word[15]) begin
          reg0 <= REG0_DEF;
          reg4 <= REG4_DEF;
          reg5 <= 16'd0;
          reg6 <= 16'd0;
          reg7 <= 16'd0;
        end else begin
          case (reg_addr)
            5'd0:    reg0 <= {1'b0, in_word[14:0]};
            5'd4:    reg4 <= in_word;
            5'd5:    reg5 <= in_word;
            5'd6:    reg6 <= in_word;
            5'd7:    reg7 <= in_word;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
